// File: rtl/bsg_dll_lock_ctrl.sv
// DLL lock controller.
// Servos a delay-line control code until the measured period count matches
// a latched target. It runs a binary search first, then +/-1 tracking, and
// declares lock after lock_cnt_p consecutive in-tolerance samples.
//
// Ports
//   clk_i         sole clock, rising edge
//   reset_n_i     synchronous active-low reset
//   en_i          level enable; low forces IDLE
//   target_i      desired period count, latched when leaving IDLE
//   meas_v_i      period-count sample valid
//   meas_i        period-count sample
//   meas_ready_o  sample accepted when meas_v_i & meas_ready_o
//   ctl_o         registered delay-line control code
//   ctl_v_o       one-cycle pulse in the cycle ctl_o takes a new value
//   locked_o      loop locked
//   err_o         sticky: correction requested beyond code range
//
// state  | meaning
// IDLE   | loop disabled, samples dropped, ctl_o held
// SEARCH | binary search on the code, step halves per bad sample
// TRACK  | +/-1 corrections, counting consecutive good samples
// LOCKED | lock declared; a bad sample drops back to TRACK
module bsg_dll_lock_ctrl #(
   parameter int count_width_p = 8,
   parameter int ctl_width_p   = 6,
   parameter int tol_p         = 1,
   parameter int lock_cnt_p    = 4,
   parameter int settle_p      = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     en_i,
   input  logic [count_width_p-1:0] target_i,
   input  logic                     meas_v_i,
   input  logic [count_width_p-1:0] meas_i,
   output logic                     meas_ready_o,
   output logic [ctl_width_p-1:0]   ctl_o,
   output logic                     ctl_v_o,
   output logic                     locked_o,
   output logic                     err_o
);

   localparam int GW = (lock_cnt_p < 2) ? 1 : $clog2(lock_cnt_p + 1);
   localparam int SW = (settle_p < 2) ? 1 : $clog2(settle_p + 1);

   localparam logic [ctl_width_p-1:0]   CTL_MAX  = '1;
   localparam logic [ctl_width_p-1:0]   CTL_MID  = ctl_width_p'(1) << (ctl_width_p - 1);
   localparam logic [ctl_width_p-1:0]   STEP_0   = ctl_width_p'(1) << (ctl_width_p - 2);
   localparam logic [count_width_p:0]   TOL      = (count_width_p + 1)'(tol_p);
   localparam logic [SW-1:0]            SETTLE   = SW'(settle_p);
   localparam logic [GW-1:0]            LOCK_N   = GW'(lock_cnt_p);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      TRACK  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [count_width_p-1:0] target_q, target_d;
   logic [ctl_width_p-1:0]   ctl_q, ctl_d;
   logic [ctl_width_p-1:0]   step_q, step_d;
   logic [GW-1:0]            good_q, good_d;
   logic [SW-1:0]            settle_q, settle_d;
   logic                     ctl_v_q, ctl_v_d;
   logic                     locked_q, locked_d;
   logic                     err_q, err_d;
   logic                     ready_q;

   // sample classification against the latched target, one bit wider so
   // the magnitude never wraps
   logic                     accept;
   logic                     low;
   logic [count_width_p:0]   mag;
   logic                     good_s;
   logic [ctl_width_p:0]     sum_up;
   logic [ctl_width_p-1:0]   srch_ctl;
   logic [ctl_width_p-1:0]   trk_ctl;
   logic                     trk_at_limit;
   logic                     track_bad;
   logic [GW-1:0]            good_inc;

   always_comb begin
      accept       = meas_v_i & ready_q;
      low          = meas_i < target_q;
      mag          = low ? ({1'b0, target_q} - {1'b0, meas_i})
                         : ({1'b0, meas_i} - {1'b0, target_q});
      good_s       = mag <= TOL;
      sum_up       = {1'b0, ctl_q} + {1'b0, step_q};
      if (low)
         srch_ctl = sum_up[ctl_width_p] ? CTL_MAX : sum_up[ctl_width_p-1:0];
      else
         srch_ctl = (ctl_q < step_q) ? '0 : (ctl_q - step_q);
      trk_at_limit = low ? (ctl_q == CTL_MAX) : (ctl_q == '0);
      trk_ctl      = low ? (ctl_q + ctl_width_p'(1)) : (ctl_q - ctl_width_p'(1));
      good_inc     = good_q + GW'(1);
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      ctl_d     = ctl_q;
      step_d    = step_q;
      good_d    = good_q;
      settle_d  = settle_q;
      ctl_v_d   = 1'b0;
      locked_d  = locked_q;
      err_d     = err_q;
      track_bad = 1'b0;

      if (!en_i) begin
         state_d  = IDLE;
         locked_d = 1'b0;
      end else if (state_q == IDLE) begin
         state_d  = SEARCH;
         target_d = target_i;
         ctl_d    = CTL_MID;
         step_d   = STEP_0;
         ctl_v_d  = 1'b1;
         settle_d = SETTLE;
         good_d   = '0;
         err_d    = 1'b0;
         locked_d = 1'b0;
      end else if (accept && (settle_q != '0)) begin
         settle_d = settle_q - SW'(1);
      end else if (accept) begin
         unique case (state_q)
            SEARCH: begin
               if (good_s) begin
                  good_d = GW'(1);
                  if (lock_cnt_p == 1) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end else begin
                     state_d = TRACK;
                  end
               end else if (step_q != '0) begin
                  step_d = step_q >> 1;
                  // a saturated step that lands on the current code is not a change
                  if (srch_ctl != ctl_q) begin
                     ctl_d    = srch_ctl;
                     ctl_v_d  = 1'b1;
                     settle_d = SETTLE;
                  end
               end else begin
                  state_d   = TRACK;
                  track_bad = 1'b1;
               end
            end
            TRACK: begin
               if (good_s) begin
                  good_d = good_inc;
                  if (good_inc == LOCK_N) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  track_bad = 1'b1;
               end
            end
            LOCKED: begin
               if (!good_s) begin
                  state_d   = TRACK;
                  locked_d  = 1'b0;
                  track_bad = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (track_bad) begin
         good_d = '0;
         if (trk_at_limit) begin
            err_d = 1'b1;
         end else begin
            ctl_d    = trk_ctl;
            ctl_v_d  = 1'b1;
            settle_d = SETTLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= IDLE;
         target_q <= '0;
         ctl_q    <= '0;
         step_q   <= '0;
         good_q   <= '0;
         settle_q <= '0;
         ctl_v_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         ctl_q    <= ctl_d;
         step_q   <= step_d;
         good_q   <= good_d;
         settle_q <= settle_d;
         ctl_v_q  <= ctl_v_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         ready_q  <= 1'b1;
      end
   end

   assign meas_ready_o = ready_q;
   assign ctl_o        = ctl_q;
   assign ctl_v_o      = ctl_v_q;
   assign locked_o     = locked_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_bsg_dll_lock_ctrl.sv
// Self-checking bench for bsg_dll_lock_ctrl with default parameters.
// A behavioural model of the lock loop (integer arithmetic) predicts every
// output each cycle; directed scenarios add checks against fixed code lists.
module tb_bsg_dll_lock_ctrl;

   localparam int MAXC   = 63;
   localparam int MIDC   = 32;
   localparam int STEP0  = 16;
   localparam int TOL    = 1;
   localparam int LOCKN  = 4;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] target = 8'd0;
   logic       meas_v = 1'b0;
   logic [7:0] meas = 8'd0;
   logic       meas_ready;
   logic [5:0] ctl;
   logic       ctl_v;
   logic       locked;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   // model state: mode 0 idle, 1 search, 2 track, 3 locked
   int m_mode = 0;
   int m_ctl = 0, m_step = 0, m_good = 0, m_settle = 0, m_tgt = 0;
   bit m_cv = 0, m_locked = 0, m_err = 0, m_ready = 0;

   logic [5:0] pulses[$];

   always #5 clk = ~clk;

   bsg_dll_lock_ctrl dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .en_i         (en),
      .target_i     (target),
      .meas_v_i     (meas_v),
      .meas_i       (meas),
      .meas_ready_o (meas_ready),
      .ctl_o        (ctl),
      .ctl_v_o      (ctl_v),
      .locked_o     (locked),
      .err_o        (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_apply(input int nc);
      m_ctl    = nc;
      m_cv     = 1'b1;
      m_settle = SETTLE;
   endtask

   task automatic model_edge(input bit rn, input bit e, input bit v, input int mv, input int tg);
      bit acc, good, up, tb;
      int ad, nc;
      if (!rn) begin
         m_mode = 0; m_ctl = 0; m_step = 0; m_good = 0; m_settle = 0; m_tgt = 0;
         m_cv = 0; m_locked = 0; m_err = 0; m_ready = 0;
         return;
      end
      acc     = v && m_ready;
      m_ready = 1;
      m_cv    = 0;
      tb      = 0;
      if (!e) begin
         m_mode = 0; m_locked = 0;
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1; m_tgt = tg; m_ctl = MIDC; m_step = STEP0; m_cv = 1;
         m_settle = SETTLE; m_good = 0; m_err = 0; m_locked = 0;
         return;
      end
      if (!acc) return;
      if (m_settle > 0) begin
         m_settle--;
         return;
      end
      ad   = mv - m_tgt;
      if (ad < 0) ad = -ad;
      good = (ad <= TOL);
      up   = (mv < m_tgt);
      if (m_mode == 1) begin
         if (good) begin
            m_good = 1;
            m_mode = (LOCKN == 1) ? 3 : 2;
            m_locked = (LOCKN == 1);
         end else if (m_step > 0) begin
            nc = up ? m_ctl + m_step : m_ctl - m_step;
            if (nc > MAXC) nc = MAXC;
            if (nc < 0) nc = 0;
            m_step = m_step / 2;
            if (nc != m_ctl) model_apply(nc);
         end else begin
            m_mode = 2; tb = 1;
         end
      end else if (m_mode == 2) begin
         if (good) begin
            m_good++;
            if (m_good == LOCKN) begin
               m_mode = 3; m_locked = 1;
            end
         end else tb = 1;
      end else begin
         if (!good) begin
            m_mode = 2; m_locked = 0; tb = 1;
         end
      end
      if (tb) begin
         m_good = 0;
         nc = up ? m_ctl + 1 : m_ctl - 1;
         if (nc < 0 || nc > MAXC) m_err = 1;
         else model_apply(nc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(reset_n, en, meas_v, int'(meas), int'(target));
      #1;
      chk("ctl_o", ctl, m_ctl);
      chk("ctl_v_o", ctl_v, m_cv);
      chk("locked_o", locked, m_locked);
      chk("err_o", err, m_err);
      chk("meas_ready_o", meas_ready, m_ready);
      if (ctl_v === 1'b1) pulses.push_back(ctl);
   endtask

   // closed-loop plant driven from the model's code, not the DUT's
   task automatic plant_tick();
      meas   = 8'(2 * m_ctl + 40);
      meas_v = 1'b1;
      tick();
   endtask

   initial begin
      int exp_srch[5] = '{32, 16, 24, 28, 30};
      int exp_sat[6]  = '{32, 48, 56, 60, 62, 63};
      int p;

      // reset with enable and valid asserted
      reset_n = 1'b0; en = 1'b1; meas_v = 1'b1; target = 8'd100; meas = 8'd0;
      pulses.delete();
      tick();
      tick();
      chk("rst_ctl_v_pulses", pulses.size(), 0);
      chk("rst_ready", meas_ready, 0);

      // binary search and lock on plant meas = 2*ctl+40
      reset_n = 1'b1;
      for (int i = 0; i < 200 && locked !== 1'b1; i++) plant_tick();
      chk("lock_reached", locked, 1);
      chk("srch_pulse_count", pulses.size(), 5);
      foreach (exp_srch[i]) if (i < pulses.size()) chk("srch_code", pulses[i], exp_srch[i]);
      chk("lock_code", ctl, 30);
      for (int i = 0; i < 5; i++) plant_tick();
      chk("lock_hold", locked, 1);

      // loss of lock
      meas = 8'd103; meas_v = 1'b1;
      tick();
      chk("lol_locked", locked, 0);
      chk("lol_code", ctl, 29);
      chk("lol_ctl_v", ctl_v, 1);

      // saturation with target 200, samples always 0
      en = 1'b0; meas_v = 1'b0;
      tick();
      pulses.delete();
      en = 1'b1; target = 8'd200; meas = 8'd0; meas_v = 1'b1;
      tick();
      chk("sat_start", ctl, 32);
      tick();
      chk("settle_1", ctl, 32);
      tick();
      chk("settle_2", ctl, 32);
      tick();
      chk("settle_3", ctl, 48);
      for (int i = 0; i < 100 && err !== 1'b1; i++) tick();
      chk("sat_err", err, 1);
      chk("sat_code", ctl, 63);
      chk("sat_no_ctl_v", ctl_v, 0);
      chk("sat_pulse_count", pulses.size(), 6);
      foreach (exp_sat[i]) if (i < pulses.size()) chk("sat_code_seq", pulses[i], exp_sat[i]);
      tick();
      chk("sat_err_sticky", err, 1);

      // enable drop mid-search
      en = 1'b0; meas_v = 1'b1;
      tick();
      chk("dis_err_hold", err, 1);
      en = 1'b1; target = 8'd100;
      tick();
      chk("reen_err_clr", err, 0);
      for (int i = 0; i < 50 && !(ctl === 6'd24 && ctl_v === 1'b1); i++) plant_tick();
      chk("mid_search_24", ctl, 24);
      en = 1'b0;
      plant_tick();
      chk("dis_ctl_hold", ctl, 24);
      chk("dis_no_ctl_v", ctl_v, 0);
      plant_tick();
      en = 1'b1;
      plant_tick();
      chk("reen_code", ctl, 32);
      chk("reen_ctl_v", ctl_v, 1);
      chk("reen_err", err, 0);

      // reset mid-operation, then restart
      for (int i = 0; i < 6; i++) plant_tick();
      reset_n = 1'b0;
      plant_tick();
      chk("midrst_ctl", ctl, 0);
      chk("midrst_ready", meas_ready, 0);
      reset_n = 1'b1;
      plant_tick();
      chk("midrst_restart", ctl, 32);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         en      = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 99) == 0) target = 8'($urandom_range(40, 166));
         meas_v  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) begin
            meas = 8'($urandom_range(0, 255));
         end else begin
            p = 2 * m_ctl + 38 + int'($urandom_range(0, 4));
            if (p > 255) p = 255;
            meas = 8'(p);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
